// File: rtl/serial_pattern_tx_if.sv
// Pattern-transmitter bus: frame request inputs and serial/status/display outputs.
interface serial_pattern_tx_if;
    logic       start;
    logic [7:0] data;
    logic [3:0] len;
    logic       rpt;
    logic       x;
    logic       busy;
    logic       done;
    logic       bit_tick;
    logic       a, b, c, d, e, f, g;

    modport master (
        output start, data, len, rpt,
        input  x, busy, done, bit_tick, a, b, c, d, e, f, g
    );

    modport slave (
        input  start, data, len, rpt,
        output x, busy, done, bit_tick, a, b, c, d, e, f, g
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial test-pattern transmitter: shifts a 1..8 bit word out MSB-first, one bit per
// DIV clocks, idle-high, with bits-remaining shown on an active-low 7-segment digit.
module serial_pattern_tx #(
    parameter int unsigned DIV   = 20000000,
    parameter int unsigned CNT_W = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_pattern_tx_if.slave   tx_if
);

    localparam int unsigned WORD_W = 8;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SEG_W  = 7;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [SEG_W-1:0] SEG_ZERO = 7'b0000001;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic [LEN_W-1:0]  flen_q,  flen_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic              x_q,     x_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              tick_q,  tick_d;
    logic [SEG_W-1:0]  seg_q,   seg_d;

    logic              len_ok_c;

    // Active-low {a..g} pattern for the bits-remaining digit.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [LEN_W-1:0] n);
        case (n)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign len_ok_c = (tx_if.len != 4'd0) && (tx_if.len <= 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            flen_q  <= '0;
            rem_q   <= '0;
            x_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
            seg_q   <= SEG_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            flen_q  <= flen_d;
            rem_q   <= rem_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
        end
    end

    // Next-state: load in IDLE, advance one bit per prescaler wrap in SHIFT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        flen_d  = flen_q;
        rem_d   = rem_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tick_d  = 1'b0;
        seg_d   = seg_q;

        case (state_q)
            S_IDLE: begin
                if (tx_if.start && len_ok_c) begin
                    word_d  = tx_if.data;
                    flen_d  = tx_if.len;
                    rem_d   = tx_if.len;
                    x_d     = tx_if.data[IDX_W'(tx_if.len - 4'd1)];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (rem_q > 4'd1) begin
                        rem_d = rem_q - 4'd1;
                        x_d   = word_q[IDX_W'(rem_q - 4'd2)];
                    end else if (tx_if.rpt) begin
                        // Repeat: reload the latched frame with no idle gap.
                        rem_d = flen_q;
                        x_d   = word_q[IDX_W'(flen_q - 4'd1)];
                    end else begin
                        rem_d   = '0;
                        x_d     = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        seg_d = seg_decode(rem_d);
    end

    assign tx_if.x        = x_q;
    assign tx_if.busy     = busy_q;
    assign tx_if.done     = done_q;
    assign tx_if.bit_tick = tick_q;
    assign {tx_if.a, tx_if.b, tx_if.c, tx_if.d, tx_if.e, tx_if.f, tx_if.g} = seg_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx at DIV=4: frame timing, segments, repeat, resets.
module tb_serial_pattern_tx;

    localparam int unsigned DIV   = 4;
    localparam int unsigned CNT_W = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    serial_pattern_tx_if tb_if ();

    serial_pattern_tx #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (tb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_exp(input int n);
        case (n)
            0: seg_exp = 7'b0000001;
            1: seg_exp = 7'b1001111;
            2: seg_exp = 7'b0010010;
            3: seg_exp = 7'b0000110;
            4: seg_exp = 7'b1001100;
            5: seg_exp = 7'b0100100;
            6: seg_exp = 7'b0100000;
            7: seg_exp = 7'b0001111;
            8: seg_exp = 7'b0000000;
            default: seg_exp = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] seg_now();
        seg_now = {tb_if.a, tb_if.b, tb_if.c, tb_if.d, tb_if.e, tb_if.f, tb_if.g};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Idle expectations for n cycles, sampled on the falling edge.
    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, ".x"},    32'(tb_if.x),    32'd1);
            check({tag, ".busy"}, 32'(tb_if.busy), 32'd0);
            check({tag, ".done"}, 32'(tb_if.done), 32'd0);
            check({tag, ".seg"},  32'(seg_now()),  32'(seg_exp(0)));
            @(negedge clk);
        end
    endtask

    // Pulse start for one edge; returns on the falling edge of the first frame cycle.
    task automatic launch(input logic [7:0] w, input logic [3:0] n);
        tb_if.start = 1'b1;
        tb_if.data  = w;
        tb_if.len   = n;
        @(negedge clk);
        tb_if.start = 1'b0;
    endtask

    // Checks every cycle of one frame; optional mid-frame rpt clear or busy-time start poke.
    task automatic expect_bits(input string tag, input logic [7:0] w, input int n,
                               input bit wrap, input bit clr_rpt, input bit poke);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < int'(DIV); j++) begin
                check({tag, ".x"},    32'(tb_if.x),        32'(w[n-1-k]));
                check({tag, ".busy"}, 32'(tb_if.busy),     32'd1);
                check({tag, ".done"}, 32'(tb_if.done),     32'd0);
                check({tag, ".tick"}, 32'(tb_if.bit_tick), 32'((j == 0) && (k > 0 || wrap)));
                check({tag, ".seg"},  32'(seg_now()),      32'(seg_exp(n - k)));
                tb_if.start = 1'b0;
                if (clr_rpt && k == 2 && j == 0) tb_if.rpt = 1'b0;
                if (poke && k == 1 && j == 1) begin
                    tb_if.start = 1'b1;
                    tb_if.data  = 8'hFF;
                    tb_if.len   = 4'd2;
                end
                @(negedge clk);
            end
        end
    endtask

    // Checks the done cycle; leaves the bench still sampling that cycle.
    task automatic expect_done(input string tag);
        check({tag, ".done"}, 32'(tb_if.done),     32'd1);
        check({tag, ".x"},    32'(tb_if.x),        32'd1);
        check({tag, ".busy"}, 32'(tb_if.busy),     32'd0);
        check({tag, ".tick"}, 32'(tb_if.bit_tick), 32'd1);
        check({tag, ".seg"},  32'(seg_now()),      32'(seg_exp(0)));
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        tb_if.start = 1'b0;
        tb_if.data  = 8'h00;
        tb_if.len   = 4'd0;
        tb_if.rpt   = 1'b0;

        @(negedge clk);
        check("rst.x",    32'(tb_if.x),        32'd1);
        check("rst.busy", 32'(tb_if.busy),     32'd0);
        check("rst.done", 32'(tb_if.done),     32'd0);
        check("rst.tick", 32'(tb_if.bit_tick), 32'd0);
        check("rst.seg",  32'(seg_now()),      32'h01);
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("idle0", 2);

        // 0011 over 4 bits: x = 0,0,1,1, done at T+17.
        launch(8'h03, 4'd4);
        expect_bits("f03", 8'h03, 4, 1'b0, 1'b0, 1'b0);
        expect_done("f03.end");
        // New start accepted in the done cycle; single-bit frame at minimum length.
        launch(8'h00, 4'd1);
        expect_bits("f1b", 8'h00, 1, 1'b0, 1'b0, 1'b0);
        expect_done("f1b.end");
        @(negedge clk);
        expect_idle("idle1", 2);

        // Illegal lengths are ignored.
        launch(8'hFF, 4'd0);
        expect_idle("len0", 4);
        launch(8'hFF, 4'd9);
        expect_idle("len9", 4);

        // Repeat mode: A5 twice back-to-back, rpt cleared in frame 2, done at T+65.
        tb_if.rpt = 1'b1;
        launch(8'hA5, 4'd8);
        expect_bits("rpt1", 8'hA5, 8, 1'b0, 1'b0, 1'b0);
        expect_bits("rpt2", 8'hA5, 8, 1'b1, 1'b1, 1'b0);
        expect_done("rpt.end");
        @(negedge clk);
        expect_idle("idle2", 2);

        // Start while busy is dropped; frame unchanged.
        launch(8'h96, 4'd8);
        expect_bits("poke", 8'h96, 8, 1'b0, 1'b0, 1'b1);
        expect_done("poke.end");
        @(negedge clk);
        expect_idle("idle3", 3);

        // Async reset mid-bit of an 8-bit frame.
        launch(8'hF0, 4'd8);
        repeat (9) @(negedge clk);
        check("mid.busy", 32'(tb_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst.x",    32'(tb_if.x),        32'd1);
        check("arst.busy", 32'(tb_if.busy),     32'd0);
        check("arst.done", 32'(tb_if.done),     32'd0);
        check("arst.tick", 32'(tb_if.bit_tick), 32'd0);
        check("arst.seg",  32'(seg_now()),      32'h01);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("idle4", 2);
        launch(8'h5C, 4'd8);
        expect_bits("post", 8'h5C, 8, 1'b0, 1'b0, 1'b0);
        expect_done("post.end");
        @(negedge clk);
        expect_idle("idle5", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial test-pattern transmitter: loads a parallel word of 1–8 bits and shifts it out MSB-first on the serial line `x`, one bit per prescaled tick. A bit count is shown on a 7-segment display. It is the driving end of the serial input consumed by the sequence-detector FSM: its idle level and bit rate match what that detector samples, so the two can be wired back-to-back on the board. Runs from the fabric system clock.

## Interface
- `DIV`, default 20000000: system-clock cycles per transmitted bit; legal range 2..2^27−1.
- `CNT_W`, default 27: prescaler counter width; must satisfy 2^CNT_W > DIV.

Ports:
- `clk`  in  1  system clock (fabric `Sys_Clk0`); all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; synchronous deassert handled externally.
- `start`  in  1  single-cycle request to begin a frame.
- `data`  in  8  pattern word; bits `[len-1:0]` are used, sent MSB (`data[len-1]`) first.
- `len`  in  4  frame length in bits, legal 1..8.
- `rpt`  in  1  repeat mode: resend the latched word back-to-back until cleared.
- `x`  out  1  serial output, registered; idle level 1.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse at frame end (non-repeat).
- `bit_tick`  out  1  one-cycle pulse at each bit boundary.
- `a,b,c,d,e,f,g`  out  1 each  7-segment, active-low, showing bits remaining.

## Operation
- State machine: IDLE, SHIFT.
- Reset (async, immediate): state IDLE; `x`=1; `busy`=0; `done`=0; `bit_tick`=0; prescaler=0; remaining=0; segments show digit 0 (`{a..g}`=0000001).
- IDLE:
  - When `start`=1 and 1≤`len`≤8, latch `data`→word, `len`→flen, and set remaining=`len`.
  - Drive `x`←`data[len-1]`, clear the prescaler, and go to SHIFT.
  - `start` with `len`=0 or `len`>8 is ignored; no state change and no `done`.
- SHIFT:
  - The prescaler counts 0..DIV−1 and wraps.
  - When the count is DIV−1, `bit_tick` pulses in the following cycle and:
    - if remaining>1: remaining−1, and `x`←word[remaining−2];
    - if remaining=1 and `rpt`=1: remaining←flen, `x`←word[flen−1]; no `done`;
    - if remaining=1 and `rpt`=0: go to IDLE, `x`←1, `busy`←0, `done` pulses.
- `start`, `data` and `len` are ignored while in SHIFT. The latched word is stable for the whole frame.
- `rpt` is sampled only at the last-bit boundary. Clearing it mid-frame finishes the current frame normally.
- Segments decode remaining (0..8), active-low `{a,b,c,d,e,f,g}`:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000
  - Outputs are registered with remaining.
- Arithmetic: remaining is 4 bits and never underflows; the prescaler compare is an equality against DIV−1.

## Timing
- `start` sampled high at edge T: `x`, `busy`=1 and the segment digit are valid after edge T (cycle T+1).
- Each bit is held exactly DIV cycles.
- Bit k (0-based) occupies cycles T+1+k·DIV .. T+k·DIV+DIV.
- Non-repeat frame: after edge T+len·DIV, `x`=1, `busy`=0, `done`=1 for one cycle, segments show 0.
- A new `start` is accepted on the cycle `done` is high (state is IDLE). Back-to-back frames therefore have no gap beyond one cycle of `x`=1.
- `bit_tick` is high during the first cycle of each new bit after the first, and during the `done` cycle.
- Repeat mode: the frame restarts with no idle cycle. `bit_tick` pulses on the wrap boundary.
- `rst_n` low mid-frame: all outputs return to reset values without waiting for a clock edge. No `done` is produced.

## Test plan
- DIV=4, `data`=8'h03, `len`=4, `start` at T → `x`=0,0,1,1, each held 4 cycles, from T+1; `done` pulse and `x`=1 at T+17; segments step 4,3,2,1,0.
- DIV=4, `len`=0 and then `len`=9 with `start` → `busy` stays 0, `x` stays 1, no `done`.
- DIV=4, `data`=8'hA5, `len`=8, `rpt`=1 for two frames, clear `rpt` during frame 2 → 1010_0101 sent twice contiguously; `done` only at the end of frame 2 (cycle T+65).
- `start` pulsed while busy with different `data` → current frame is unaffected; the second request is dropped.
- `rst_n` asserted mid-bit of an 8-bit frame → `x`=1, `busy`=0, segments show 0 immediately; a `start` after release sends a full new frame.
- Loopback to the sequence detector, DIV=4, pattern 0011 (`len`=4) → detector output goes 0 on the final bit; `x` idle 1 keeps the detector in its initial state.
